// File: rtl/sprite_mover.sv
// sprite_mover: per-frame motion controller for one 8x8 sprite.
// Sits between the CPU and the sprite register file. On each rising vsync
// edge (with enable high) it reads X/Y (regs 8/9), steps them by speed_x/y,
// bounces off 0 and XMAX/YMAX, and writes them back. While idle the CPU bus
// passes straight through.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   vsync, enable       frame tick source, motion enable (sampled on the tick)
//   speed_x, speed_y    step magnitude per frame, 0..7
//   cpu_we/oe/addr/di   CPU register bus (ignored while busy)
//   cpu_dout            read data back to the CPU (wire from spr_dout)
//   busy                mover owns the sprite bus
//   spr_we/oe/addr/di   bus to the sprite register file
//   spr_dout            read data from the sprite register file
//   dir_x, dir_y        current direction, 1 = decreasing
//   frames              completed updates, wrapping
module sprite_mover #(
  parameter int XMAX = 248,
  parameter int YMAX = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       enable,
  input  logic [2:0] speed_x,
  input  logic [2:0] speed_y,
  input  logic       cpu_we,
  input  logic       cpu_oe,
  input  logic [3:0] cpu_addr,
  input  logic [7:0] cpu_di,
  output logic [7:0] cpu_dout,
  output logic       busy,
  output logic       spr_we,
  output logic       spr_oe,
  output logic [3:0] spr_addr,
  output logic [7:0] spr_di,
  input  logic [7:0] spr_dout,
  output logic       dir_x,
  output logic       dir_y,
  output logic [7:0] frames
);
  localparam logic [7:0] XM = 8'(XMAX);
  localparam logic [7:0] YM = 8'(YMAX);
  localparam logic [3:0] ADDR_X = 4'd8;
  localparam logic [3:0] ADDR_Y = 4'd9;

  typedef enum logic [2:0] {IDLE, RD_X, RD_Y, CALC, WR_X, WR_Y} state_t;

  state_t     state;
  logic       vs_d;
  logic       tick;
  logic [2:0] sx, sy;
  logic [7:0] x, y, nx, ny;
  logic [8:0] stx, sty;

  // One axis step; returns {new_dir, new_pos}. 9-bit compare keeps p+s
  // from wrapping, and >= makes a position already at the limit flip even
  // with a zero step.
  function automatic logic [8:0] step(input logic [7:0] p, input logic [2:0] s,
                                      input logic dir, input logic [7:0] pmax);
    logic [8:0] sum;
    sum = {1'b0, p} + {6'd0, s};
    if (!dir) begin
      if (sum >= {1'b0, pmax}) step = {1'b1, pmax};
      else                     step = {1'b0, sum[7:0]};
    end else begin
      if ({1'b0, p} <= {6'd0, s}) step = 9'h000;
      else                        step = {1'b1, p - {5'd0, s}};
    end
  endfunction

  assign tick     = vsync & ~vs_d;
  assign cpu_dout = spr_dout;
  assign stx      = step(x, sx, dir_x, XM);
  assign sty      = step(y, sy, dir_y, YM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      vs_d   <= 1'b1;
      dir_x  <= 1'b0;
      dir_y  <= 1'b0;
      frames <= 8'd0;
      x      <= 8'd0;
      y      <= 8'd0;
      nx     <= 8'd0;
      ny     <= 8'd0;
      sx     <= 3'd0;
      sy     <= 3'd0;
    end else begin
      vs_d <= vsync;
      case (state)
        IDLE: if (tick && enable) begin
          sx    <= speed_x;
          sy    <= speed_y;
          state <= RD_X;
        end
        // The register file latches read data on the negedge inside the
        // strobe cycle, so X's data is taken on the edge that enters RD_Y
        // (before the RD_Y read overwrites it), and Y's on the edge into CALC.
        RD_X: begin x <= spr_dout; state <= RD_Y; end
        RD_Y: begin y <= spr_dout; state <= CALC; end
        CALC: begin
          {dir_x, nx} <= stx;
          {dir_y, ny} <= sty;
          state       <= WR_X;
        end
        WR_X: state <= WR_Y;
        WR_Y: begin frames <= frames + 8'd1; state <= IDLE; end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = 1'b1;
    spr_we   = 1'b0;
    spr_oe   = 1'b0;
    spr_addr = 4'd0;
    spr_di   = 8'd0;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        spr_we   = cpu_we;
        spr_oe   = cpu_oe;
        spr_addr = cpu_addr;
        spr_di   = cpu_di;
      end
      RD_X: begin spr_oe = 1'b1; spr_addr = ADDR_X; end
      RD_Y: begin spr_oe = 1'b1; spr_addr = ADDR_Y; end
      WR_X: begin spr_we = 1'b1; spr_addr = ADDR_X; spr_di = nx; end
      WR_Y: begin spr_we = 1'b1; spr_addr = ADDR_Y; spr_di = ny; end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_sprite_mover.sv
// Testbench for sprite_mover: register-file model on the sprite bus, a
// queue of expected write-backs popped by a negedge monitor, and a
// position/direction model driven from the motion rules.
module tb_sprite_mover;
  localparam int XMAX = 248;
  localparam int YMAX = 120;

  logic       clk = 0;
  logic       reset, vsync, enable;
  logic [2:0] speed_x, speed_y;
  logic       cpu_we, cpu_oe;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_di, cpu_dout;
  logic       busy, spr_we, spr_oe;
  logic [3:0] spr_addr;
  logic [7:0] spr_di, spr_dout;
  logic       dir_x, dir_y;
  logic [7:0] frames;

  sprite_mover #(.XMAX(XMAX), .YMAX(YMAX)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .enable(enable),
    .speed_x(speed_x), .speed_y(speed_y),
    .cpu_we(cpu_we), .cpu_oe(cpu_oe), .cpu_addr(cpu_addr), .cpu_di(cpu_di),
    .cpu_dout(cpu_dout), .busy(busy),
    .spr_we(spr_we), .spr_oe(spr_oe), .spr_addr(spr_addr), .spr_di(spr_di),
    .spr_dout(spr_dout), .dir_x(dir_x), .dir_y(dir_y), .frames(frames)
  );

  always #5 clk = ~clk;

  // Sprite register file: writes and read latching on negedge.
  logic [7:0] rf [16];
  logic [7:0] rf_dout;
  assign spr_dout = rf_dout;
  always @(negedge clk) begin
    if (spr_we) rf[spr_addr] <= spr_di;
    if (spr_oe) rf_dout <= rf[spr_addr];
  end

  int n_cmp = 0, n_fail = 0;
  int busy_cycles = 0;
  logic [11:0] exp_q [$];

  // Reference state: positions, directions, completed frames.
  int mx = 0, my = 0, mdx = 0, mdy = 0, mf = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void mstep(inout int p, inout int d, input int s, input int lim);
    if (d == 0) begin
      if (p + s >= lim) begin p = lim; d = 1; end
      else p = p + s;
    end else begin
      if (p <= s) begin p = 0; d = 0; end
      else p = p - s;
    end
  endfunction

  // Monitor: every mover write-back must match the next expected one.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (busy && spr_we) begin
        if (exp_q.size() == 0) chk("unexpected_wr", {spr_addr, spr_di}, 0);
        else begin
          e = exp_q.pop_front();
          chk("wr_addr_data", {spr_addr, spr_di}, e);
        end
      end
    end
  end

  task automatic cpu_write(input int a, input int d);
    cpu_we = 1; cpu_addr = 4'(a); cpu_di = 8'(d);
    #1;
    chk("pass_we", spr_we, 1);
    chk("pass_addr", spr_addr, a);
    chk("pass_di", spr_di, d);
    @(posedge clk); #1;
    cpu_we = 0;
    if (a == 8) mx = d;
    if (a == 9) my = d;
  endtask

  task automatic cpu_read(input int a, input int exp);
    cpu_oe = 1; cpu_addr = 4'(a);
    @(posedge clk); #1;
    cpu_oe = 0;
    chk("cpu_dout", cpu_dout, exp);
  endtask

  // One vsync frame. hold: cycles vsync stays high after the tick edge;
  // inj: cycle index of a CPU write to reg 8 (1 = RD_Y); rst_at: cycle index
  // in which reset is held (3 = WR_X, so WR_Y never happens); retick: cycle
  // index of a second vsync pulse. Cycle 0 is RD_X.
  task automatic do_frame(input bit en, input int sx, input int sy,
                          input int hold, input int inj, input int rst_at,
                          input int retick);
    int b0, n, ox, oy;
    b0 = busy_cycles;
    oy = my;
    if (en) begin
      mstep(mx, mdx, sx, XMAX);
      mstep(my, mdy, sy, YMAX);
      exp_q.push_back({4'd8, 8'(mx)});
      if (rst_at == 0) begin
        exp_q.push_back({4'd9, 8'(my)});
        mf = (mf + 1) % 256;
      end else begin
        my = oy; mdx = 0; mdy = 0; mf = 0;
      end
    end
    ox = mx;
    speed_x = 3'(sx); speed_y = 3'(sy); enable = en; vsync = 1;
    @(posedge clk); #1;
    n = (hold + 3 > 9) ? hold + 3 : 9;
    for (int c = 0; c < n; c++) begin
      vsync  = (c < hold) || (c == retick && retick != 0);
      reset  = (rst_at != 0 && c == rst_at);
      cpu_we = (inj != 0 && c == inj);
      if (cpu_we) begin
        cpu_addr = 4'd8; cpu_di = 8'h40;
        #1;
        chk("busy_drop_we", spr_we, 0);
        chk("busy_flag", busy, 1);
      end
      @(posedge clk); #1;
    end
    cpu_we = 0; reset = 0; vsync = 0;
    chk("busy_len", busy_cycles - b0, en ? (rst_at != 0 ? rst_at + 1 : 5) : 0);
    chk("dir_x", dir_x, mdx);
    chk("dir_y", dir_y, mdy);
    chk("frames", frames, mf);
    chk("rf_x", rf[8], ox);
    chk("rf_y", rf[9], my);
    if (exp_q.size() != 0) begin
      chk("missing_wr", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    reset = 1; vsync = 1; enable = 1; speed_x = 0; speed_y = 0;
    cpu_we = 0; cpu_oe = 0; cpu_addr = 0; cpu_di = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_frames", frames, 0);
    chk("rst_dir_x", dir_x, 0);
    chk("rst_dir_y", dir_y, 0);
    chk("rst_spr_we", spr_we, 0);
    chk("rst_spr_oe", spr_oe, 0);
    reset = 0;
    repeat (4) @(posedge clk); #1;
    chk("no_tick_at_release", busy_cycles, 0);
    vsync = 0;
    @(posedge clk); #1;

    cpu_write(3, 8'h5A);
    cpu_read(3, 8'h5A);
    cpu_write(8, 10);
    cpu_write(9, 20);
    do_frame(1, 1, 1, 1, 0, 0, 0);        // 10/20 -> 11/21
    cpu_write(8, 247);
    do_frame(1, 3, 0, 1, 0, 0, 0);        // 248, dir_x=1
    do_frame(1, 3, 0, 1, 0, 0, 0);        // 245
    cpu_write(8, 2);
    do_frame(1, 3, 0, 1, 0, 0, 0);        // 0, dir_x=0
    do_frame(1, 3, 0, 1, 0, 0, 0);        // 3
    cpu_write(9, 119);
    do_frame(1, 0, 2, 1, 0, 0, 0);        // y=120, dir_y=1
    do_frame(1, 2, 1, 30, 0, 0, 0);       // vsync held high: one update
    do_frame(0, 5, 5, 1, 0, 0, 0);        // enable low: nothing
    do_frame(1, 4, 3, 1, 0, 0, 2);        // tick mid-update dropped
    do_frame(1, 1, 1, 1, 1, 0, 0);        // CPU write in RD_Y discarded
    cpu_write(8, 8'h40);
    cpu_read(8, 8'h40);
    do_frame(1, 2, 2, 1, 0, 3, 0);        // reset before WR_Y: X only

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0) cpu_write($urandom_range(8, 9), $urandom_range(0, 255));
      do_frame($urandom_range(0, 4) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(1, 4), 0, 0, $urandom_range(0, 1) * 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
